// File: rtl/fifo_rd_pkg.sv
// Shared definitions for the FIFO burst reader: FSM state encoding,
// skid buffer depth and a counter-width helper.
package fifo_rd_pkg;

  // Burst reader control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } rd_state_t;

  // Output skid buffer depth and the width of its occupancy count (0..2).
  localparam int SKID_DEPTH = 2;
  localparam int SKID_CW    = 2;

  // Number of bits needed to hold values 0..max_val (at least 1).
  function automatic int cnt_width(input int max_val);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) <= max_val) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/fifo_burst_reader_if.sv
// Bus bundle of the FIFO burst reader: start/len command, FIFO read side,
// output stream and status.
//
// Stream handshake: m_valid/m_data are driven by the reader, m_ready by the
// consumer. A word transfers on every rising edge where m_valid & m_ready.
// Once m_valid is high, m_valid and m_data hold steady until the transfer.
// m_valid never depends combinationally on m_ready.
interface fifo_burst_reader_if #(
  parameter int WL = 8,
  parameter int LW = 8
);
  import fifo_rd_pkg::*;

  logic          start;
  logic [LW-1:0] len;
  logic          fifo_empty;
  logic [WL-1:0] fifo_dout;
  logic          fifo_rReq;
  logic [WL-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          busy;
  logic          done;
  logic          timeout;
  rd_state_t     dbg_state;

  // Reader side.
  modport master (
    input  start, len, fifo_empty, fifo_dout, m_ready,
    output fifo_rReq, m_data, m_valid, busy, done, timeout, dbg_state
  );

  // Environment side: command source, FIFO and stream consumer.
  modport slave (
    output start, len, fifo_empty, fifo_dout, m_ready,
    input  fifo_rReq, m_data, m_valid, busy, done, timeout, dbg_state
  );

endinterface

// File: rtl/fifo_rd_skid.sv
// Two-entry skid buffer between the FIFO's registered read data and the
// output stream. head holds the word presented on the stream, tail the one
// behind it.
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int WL = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               wr_en_i,
  input  logic [WL-1:0]      wr_data_i,
  input  logic               m_ready_i,
  output logic               m_valid_o,
  output logic [WL-1:0]      m_data_o,
  output logic [SKID_CW-1:0] count_o
);

  localparam logic [SKID_CW-1:0] CNT_ONE = 1;

  logic [WL-1:0]      head_q, head_d;
  logic [WL-1:0]      tail_q, tail_d;
  logic [SKID_CW-1:0] cnt_q, cnt_d;
  logic               rd;

  assign m_valid_o = (cnt_q != '0);
  assign m_data_o  = head_q;
  assign count_o   = cnt_q;
  assign rd        = m_valid_o & m_ready_i;

  // Next entry contents and occupancy for write, read, or both at once.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    case ({wr_en_i, rd})
      2'b10: begin
        if (cnt_q == '0) head_d = wr_data_i;
        else             tail_d = wr_data_i;
        cnt_d = cnt_q + CNT_ONE;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - CNT_ONE;
      end
      2'b11: begin
        // A read implies at least one entry; the count stays the same.
        if (cnt_q == CNT_ONE) begin
          head_d = wr_data_i;
        end else begin
          head_d = tail_q;
          tail_d = wr_data_i;
        end
      end
      default: ;
    endcase
  end

  // Entry and occupancy registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// FIFO burst reader: on start, pops exactly len words from a synchronous
// FIFO (registered dout, one-cycle read latency) and streams them out
// through a two-entry skid buffer, then pulses done.
// Optional feature macro: FIFO_RD_TIMEOUT_EN enables the starve counter
// that aborts a burst after TIMEOUT empty cycles.
module fifo_burst_reader
  import fifo_rd_pkg::*;
#(
  parameter int WL      = 8,
  parameter int LW      = 8,
  parameter int TIMEOUT = 256
) (
  input logic                CLK,
  input logic                RST,
  fifo_burst_reader_if.master bus
);

  localparam logic [LW-1:0]      LEN_ONE   = 1;
  localparam logic [SKID_CW:0]   OCC_LIMIT = (SKID_CW + 1)'(SKID_DEPTH);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("fifo_burst_reader: TIMEOUT must be at least 1");
  end

  rd_state_t          state_q, state_d;
  logic [LW-1:0]      len_q, len_d;
  logic [LW-1:0]      req_cnt_q, req_cnt_d;
  logic [LW-1:0]      out_cnt_q, out_cnt_d;
  logic               inflight_q;

  logic               pop;
  logic               xfer;
  logic               last_xfer;
  logic               skid_valid;
  logic [WL-1:0]      skid_data;
  logic [SKID_CW-1:0] skid_cnt;
  logic [SKID_CW:0]   occ;
  logic               pop_block;
  logic               abort;

  // Words committed to the skid: buffered + one in flight from the FIFO,
  // minus the one leaving this cycle. Counting the departing word lets a
  // continuously ready consumer get one word per cycle.
  assign occ = {1'b0, skid_cnt}
             + {{SKID_CW{1'b0}}, inflight_q}
             - {{SKID_CW{1'b0}}, xfer};

  assign xfer      = skid_valid & bus.m_ready;
  assign last_xfer = xfer & (out_cnt_q == len_q - LEN_ONE);

  // Pop only with data available, words still owed and guaranteed room.
  assign pop = (state_q == ST_RUN) & ~bus.fifo_empty & (req_cnt_q < len_q)
             & (occ < OCC_LIMIT) & ~pop_block;

`ifdef FIFO_RD_TIMEOUT_EN
  localparam int            TW         = cnt_width(TIMEOUT);
  localparam logic [TW-1:0] STARVE_ONE = 1;
  localparam logic [TW-1:0] STARVE_MAX = TW'(TIMEOUT - 1);

  logic [TW-1:0] starve_q, starve_d;
  logic          starved_q, starved_d;
  logic          starving;
  logic          starve_hit;

  assign starving   = (state_q == ST_RUN) & ~starved_q & bus.fifo_empty
                    & (req_cnt_q < len_q);
  assign starve_hit = starving & (starve_q == STARVE_MAX);
  assign pop_block  = starved_q;
  assign abort      = starved_q | starve_hit;
  assign bus.timeout = (state_q == ST_FIN) & starved_q;

  // Count consecutive starved RUN cycles; the abort flag lives until IDLE.
  always_comb begin
    starve_d  = starve_q;
    starved_d = starved_q;
    if (state_q == ST_IDLE) begin
      starve_d  = '0;
      starved_d = 1'b0;
    end else if (state_q == ST_RUN) begin
      if (pop) begin
        starve_d = '0;
      end else if (starving) begin
        if (starve_hit) starved_d = 1'b1;
        else            starve_d  = starve_q + STARVE_ONE;
      end
    end
  end

  // Starve counter and abort flag registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      starve_q  <= '0;
      starved_q <= 1'b0;
    end else begin
      starve_q  <= starve_d;
      starved_q <= starved_d;
    end
  end
`else
  assign pop_block   = 1'b0;
  assign abort       = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  // Next state and burst counters.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    req_cnt_d = req_cnt_q;
    out_cnt_d = out_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          len_d     = bus.len;
          req_cnt_d = '0;
          out_cnt_d = '0;
          state_d   = (bus.len != '0) ? ST_RUN : ST_FIN;
        end
      end
      ST_RUN: begin
        if (pop) req_cnt_d = req_cnt_q + LEN_ONE;
        if (xfer && (out_cnt_q < len_q)) out_cnt_d = out_cnt_q + LEN_ONE;
        if (last_xfer || (abort && (skid_cnt == '0) && !inflight_q))
          state_d = ST_FIN;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, captured length, counters and the one-cycle read-latency flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      req_cnt_q  <= '0;
      out_cnt_q  <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      req_cnt_q  <= req_cnt_d;
      out_cnt_q  <= out_cnt_d;
      inflight_q <= pop;
    end
  end

  // fifo_dout is valid the cycle after a pop; capture it then.
  fifo_rd_skid #(.WL(WL)) u_skid (
    .clk_i     (CLK),
    .rst_i     (RST),
    .wr_en_i   (inflight_q),
    .wr_data_i (bus.fifo_dout),
    .m_ready_i (bus.m_ready),
    .m_valid_o (skid_valid),
    .m_data_o  (skid_data),
    .count_o   (skid_cnt)
  );

  assign bus.fifo_rReq = pop;
  assign bus.m_valid   = skid_valid;
  assign bus.m_data    = skid_data;
  assign bus.busy      = (state_q == ST_RUN);
  assign bus.done      = (state_q == ST_FIN);
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: behavioural FIFO, scoreboard of expected
// stream words, randomized burst lengths, data and consumer backpressure.
module tb_fifo_burst_reader;
  import fifo_rd_pkg::*;

  localparam int WL = 8;
  localparam int LW = 8;
`ifdef FIFO_RD_TIMEOUT_EN
  localparam int TO  = 4;
  localparam int GAP = 2;
`else
  localparam int TO  = 256;
  localparam int GAP = 5;
`endif

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  fifo_burst_reader_if #(.WL(WL), .LW(LW)) bus ();

  fifo_burst_reader #(.WL(WL), .LW(LW), .TIMEOUT(TO)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- behavioural FIFO ----------------
  logic [WL-1:0] fmem [0:1023];
  int            f_wr = 0;
  int            f_rd = 0;
  logic          f_wr_en;
  logic [WL-1:0] f_wr_data;

  assign bus.fifo_empty = (f_wr == f_rd);

  always @(posedge CLK) begin
    if (f_wr_en) begin
      fmem[f_wr % 1024] <= f_wr_data;
      f_wr <= f_wr + 1;
    end
    if (bus.fifo_rReq && (f_wr != f_rd)) begin
      bus.fifo_dout <= fmem[f_rd % 1024];
      f_rd <= f_rd + 1;
    end
  end

  // ---------------- consumer backpressure ----------------
  int ready_mode = 0;
  always @(posedge CLK) begin
    #1;
    if (ready_mode == 1) bus.m_ready = 1'($urandom_range(0, 1));
    else                 bus.m_ready = 1'b1;
  end

  // ---------------- scoreboard ----------------
  logic [WL-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  int n_pop = 0, n_xfer = 0, n_done = 0, n_to = 0, n_busy = 0;
  int outstanding = 0;
  int last_xfer_cyc = 0, done_cyc = 0;
  int first_pop_cyc = -1, first_xfer_cyc = -1;

  // Observe every cycle on the falling edge.
  always @(negedge CLK) begin
    if (RST) begin
      outstanding = 0;
    end else begin
      if (bus.fifo_rReq) begin
        check_eq("rreq_while_empty", 32'(bus.fifo_empty), 0);
        n_pop++;
        outstanding++;
        if (first_pop_cyc < 0) first_pop_cyc = cyc;
      end
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) check_eq("word_expected", 32'(exp_q.size() != 0), 1);
        else                   check_eq("m_data", 32'(bus.m_data), 32'(exp_q.pop_front()));
        n_xfer++;
        outstanding--;
        last_xfer_cyc = cyc;
        if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
      end
      if (bus.fifo_rReq) check_eq("outstanding_le2", 32'(outstanding <= 2), 1);
      if (bus.done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (bus.timeout) n_to++;
      if (bus.busy) n_busy++;
    end
  end

  // ---------------- driver tasks ----------------
  int s_cyc, pop0, xfer0, done0, busy0, to0;

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic fifo_push(input logic [WL-1:0] d);
    f_wr_en   = 1'b1;
    f_wr_data = d;
    tick();
    f_wr_en   = 1'b0;
    exp_q.push_back(d);
  endtask

  task automatic fifo_fill_random(input int n);
    for (int i = 0; i < n; i++) fifo_push(WL'($urandom_range(0, 255)));
  endtask

  task automatic start_burst(input int l);
    pop0  = n_pop;
    xfer0 = n_xfer;
    done0 = n_done;
    busy0 = n_busy;
    to0   = n_to;
    first_pop_cyc  = -1;
    first_xfer_cyc = -1;
    bus.len   = l[LW-1:0];
    bus.start = 1'b1;
    s_cyc     = cyc;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int i;
    i = 0;
    while (n_done == done0 && i < budget) begin
      tick();
      i++;
    end
    check_eq("done_within_budget", 32'(n_done != done0), 1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int l, i, d_before;
    RST = 1'b1;
    bus.start = 1'b0;
    bus.len   = '0;
    bus.m_ready = 1'b1;
    f_wr_en   = 1'b0;
    f_wr_data = '0;
    repeat (3) tick();

    check_eq("rst_busy",    32'(bus.busy), 0);
    check_eq("rst_done",    32'(bus.done), 0);
    check_eq("rst_m_valid", 32'(bus.m_valid), 0);
    check_eq("rst_rreq",    32'(bus.fifo_rReq), 0);
    check_eq("rst_timeout", 32'(bus.timeout), 0);
    check_eq("rst_m_data",  32'(bus.m_data), 0);
    check_eq("rst_state",   32'(bus.dbg_state), 32'(ST_IDLE));
    RST = 1'b0;
    tick();

    // 1: four prefilled words, consumer always ready
    for (int k = 0; k < 4; k++) fifo_push(WL'(8'h11 + k));
    start_burst(4);
    wait_done(50);
    check_eq("t1_pops",        n_pop - pop0, 4);
    check_eq("t1_xfers",       n_xfer - xfer0, 4);
    check_eq("t1_first_pop",   first_pop_cyc - s_cyc, 1);
    check_eq("t1_first_valid", first_xfer_cyc - s_cyc, 3);
    check_eq("t1_back_to_back", last_xfer_cyc - first_xfer_cyc, 3);
    check_eq("t1_done_lat",    done_cyc - last_xfer_cyc, 1);
    check_eq("t1_exp_empty",   exp_q.size(), 0);
    tick();
    check_eq("t1_busy_after",  32'(bus.busy), 0);

    // 2: zero-length burst
    start_burst(0);
    wait_done(10);
    repeat (3) tick();
    check_eq("t2_pops",     n_pop - pop0, 0);
    check_eq("t2_done_lat", done_cyc - s_cyc, 1);
    check_eq("t2_one_done", n_done - done0, 1);
    check_eq("t2_busy",     n_busy - busy0, 0);

    // 3: len=6 with random backpressure, then random bursts
    ready_mode = 1;
    fifo_fill_random(6);
    start_burst(6);
    wait_done(300);
    check_eq("t3_pops",      n_pop - pop0, 6);
    check_eq("t3_xfers",     n_xfer - xfer0, 6);
    check_eq("t3_exp_empty", exp_q.size(), 0);
    for (int r = 0; r < 4; r++) begin
      l = $urandom_range(1, 12);
      fifo_fill_random(l);
      start_burst(l);
      wait_done(400);
      check_eq("rnd_pops",      n_pop - pop0, l);
      check_eq("rnd_xfers",     n_xfer - xfer0, l);
      check_eq("rnd_exp_empty", exp_q.size(), 0);
      check_eq("rnd_done_lat",  done_cyc - last_xfer_cyc, 1);
      tick();
    end
    ready_mode = 0;
    repeat (2) tick();

    // 4: FIFO initially empty, words trickle in
    start_burst(3);
    for (int k = 0; k < 3; k++) begin
      repeat (GAP) tick();
      fifo_push(WL'(8'hA0 + k));
    end
    wait_done(100);
    check_eq("t4_xfers",    n_xfer - xfer0, 3);
    check_eq("t4_done_lat", done_cyc - last_xfer_cyc, 1);
    check_eq("t4_no_abort", n_to - to0, 0);
    tick();
`ifdef FIFO_RD_TIMEOUT_EN
    start_burst(3);
    wait_done(40);
    check_eq("t4_to_pulse",  n_to - to0, 1);
    check_eq("t4_to_pops",   n_pop - pop0, 0);
    check_eq("t4_to_lat",    done_cyc - s_cyc, TO + 1);
    tick();
`endif

    // 6: start while busy and len change mid-burst are ignored
    fifo_fill_random(5);
    start_burst(5);
    tick();
    bus.len   = LW'(9);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(100);
    repeat (4) tick();
    check_eq("t6_pops",     n_pop - pop0, 5);
    check_eq("t6_xfers",    n_xfer - xfer0, 5);
    check_eq("t6_one_done", n_done - done0, 1);
    check_eq("t6_idle",     32'(bus.busy), 0);

    // 5: asynchronous reset mid-burst, then resume from the FIFO
    fifo_fill_random(8);
    start_burst(5);
    i = 0;
    while ((n_xfer - xfer0) < 2 && i < 50) begin
      tick();
      i++;
    end
    check_eq("t5_two_xfers", n_xfer - xfer0, 2);
    #2 RST = 1'b1;
    #1;
    check_eq("t5_rst_busy",    32'(bus.busy), 0);
    check_eq("t5_rst_m_valid", 32'(bus.m_valid), 0);
    check_eq("t5_rst_rreq",    32'(bus.fifo_rReq), 0);
    check_eq("t5_rst_m_data",  32'(bus.m_data), 0);
    check_eq("t5_rst_done",    32'(bus.done), 0);
    d_before = n_done;
    tick();
    RST = 1'b0;
    repeat (2) tick();
    check_eq("t5_no_done_on_rst", n_done - d_before, 0);
    // Words popped but not transferred are gone; the rest remain queued.
    exp_q.delete();
    for (int k = f_rd; k < f_wr; k++) exp_q.push_back(fmem[k % 1024]);
    start_burst(2);
    wait_done(50);
    check_eq("t5_resume_xfers", n_xfer - xfer0, 2);
    tick();
    l = exp_q.size();
    start_burst(l);
    wait_done(100);
    check_eq("t5_drain_xfers", n_xfer - xfer0, l);
    check_eq("t5_exp_empty",   exp_q.size(), 0);

`ifndef FIFO_RD_TIMEOUT_EN
    check_eq("timeout_never", n_to, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
